multiword_add_seq: RTL
======================

Name: multiword_add_seq

Overview:
- Multi-precision add/subtract sequencer; drives one shared external N-bit ripple adder over WORDS consecutive cycles, least-significant word first.
- Produces a WORDS*N-bit result. The carry out of each word is registered and fed into the next word's carry in.
- Sits between an operand producer and a result consumer; both sides use valid/ready handshakes. The adder stays purely combinational outside this block.

Parameters:
- N, 16, adder word width in bits.
- WORDS, 4, number of words per operand (total width W = N*WORDS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry in for word 0; ignored when in_sub=1.
- in_sub  in  1  1 = compute A-B; 0 = compute A+B+cin.
- add_a  out  N  word of A presented to the adder.
- add_b  out  N  word of effective B presented to the adder.
- add_cin  out  1  carry presented to the adder.
- add_sum  in  N  adder sum (combinational from add_a, add_b, add_cin).
- add_co  in  1  adder carry out.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W  result.
- out_co  out  1  final carry out; for subtract, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow of the W-bit operation.
- busy  out  1  state is not IDLE.

Behaviour:
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a, B_eff = in_sub ? ~in_b : in_b, and carry = in_sub ? 1 : in_cin. Clear idx, go to RUN.
  - RUN: add_a = A[idx*N +: N], add_b = B_eff[idx*N +: N], add_cin = carry. Each cycle: sum word idx <= add_sum, carry <= add_co, idx++. On idx == WORDS-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Timing, with handshake at edge T:
  - RUN occupies cycles T+1 .. T+WORDS.
  - out_valid rises at cycle T+WORDS+1.
  - in_ready returns the cycle after the output handshake. There is no same-cycle turnaround.
- out_co = carry register after the last word.
- out_ovf is computed in the last RUN cycle as (A msb == B_eff msb) && (add_sum msb != A msb), then registered.
- out_sum, out_co and out_ovf stay stable throughout DONE, including under backpressure.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- add_a, add_b and add_cin are 0 when the state is not RUN.
- Reset:
  - All state returns to IDLE with idx=0 and carry=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_co=0, out_ovf=0, busy=0, add_*=0.
- Reset asserted during RUN or DONE aborts the operation. The next cycle is IDLE with no out_valid pulse.
- Reset has priority over every handshake.
- WORDS=1: a single RUN cycle, so out_valid rises at T+2.
- idx width is clog2(WORDS), minimum 1.

Test Plan:
(Bench connects the team's N=16 ripple adder to add_*; W=64.)
- Add with ripple: A=0x0000_0000_0000_FFFF, B=0x1, cin=0, sub=0 -> out_sum=0x0000_0000_0001_0000, co=0, ovf=0; out_valid first high exactly 5 cycles after the accept edge.
- Full carry chain: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> out_sum=0, co=1, ovf=0; add_cin=1 in all four RUN cycles.
- Subtract with borrow: A=5, B=7, sub=1, cin=1 (must be ignored) -> out_sum=0xFFFF_FFFF_FFFF_FFFE, co=0, ovf=0. Then A=7, B=5 -> out_sum=2, co=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> out_sum=0x8000_0000_0000_0000, ovf=1, co=0. Then A=0x8000_0000_0000_0000, B=1, sub -> out_sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid -> out_valid and out_sum hold, in_ready=0, no new accept. Raise out_ready -> in_ready=1 on the following cycle.
- Reset mid-operation: assert rst for 1 cycle at T+2 -> next cycle state IDLE, in_ready=1, out_valid=0, add_*=0, and out_valid never pulses. A fresh add 3+4 afterwards returns out_sum=7.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS words of A and B through a
// shared external N-bit adder LSW first, chaining the carry through a register.
module multiword_add_seq #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   in_a,
  input  logic [N*WORDS-1:0]   in_b,
  input  logic                 in_cin,
  input  logic                 in_sub,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_co,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   out_sum,
  output logic                 out_co,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int          W  = N * WORDS;
  localparam int          IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WU = WORDS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          last_word;

  assign last_word = (idx_q == IW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state; subtraction is A + ~B + 1, so B is inverted once at accept.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WU; i++) begin
          if (idx_q == IW'(i)) sum_d[i*N +: N] = add_sum;
        end
        carry_d = add_co;
        idx_d   = idx_q + IW'(1);
        if (last_word) begin
          ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_sum   = sum_q;
    out_co    = carry_q;
    out_ovf   = ovf_q;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (state_q == RUN) begin
      for (int unsigned i = 0; i < WU; i++) begin
        if (idx_q == IW'(i)) begin
          add_a = a_q[i*N +: N];
          add_b = b_q[i*N +: N];
        end
      end
      add_cin = carry_q;
    end
  end

endmodule
